pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_pkg.sv | 9 +
 rtl/pipe_skid_stage_reg.sv | 15 +
 rtl/pipe_skid_stage.sv | 55 +++++
 tb/tb_pipe_skid_stage.sv | 95 +++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: shared constants and the skid-stage state encoding
package pipe_skid_stage_pkg;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_skid_stage_reg.sv
// pipe_skid_stage_reg: write-enabled storage register with sync reset value (clk, rst, din, dout, wen)
module pipe_skid_stage_reg #(
  parameter int W = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  always_ff @(posedge clk)
    if (rst) dout <= RST_VAL;
    else if (wen) dout <= din;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage, two-entry skid (SKID=1) or single register (SKID=0); in/out handshakes, flush, occupancy
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter bit SKID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);
  state_e state, state_nxt;
  logic rdy_q, in_fire, out_fire, main_wen, skid_wen;
  logic [DATA_W-1:0] main_q, skid_q, main_din, skid_din;
  // rdy_q resets high; masking with rst keeps ready low during reset and high on the first cycle after
  assign in_ready_o  = ~rst & (SKID ? rdy_q : (~out_valid_o | out_ready_i));
  assign out_valid_o = state != ST_EMPTY;
  assign out_data_o  = out_valid_o ? main_q : BUBBLE_VAL;
  assign occ_o       = state;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  always_comb begin
    state_nxt = flush_i ? ST_EMPTY :
                state == ST_EMPTY ? (in_fire ? ST_BUSY : ST_EMPTY) :
                state == ST_FULL  ? (out_fire ? ST_BUSY : ST_FULL) :
                (in_fire & ~out_fire) ? ST_FULL :
                (~in_fire & out_fire) ? ST_EMPTY : ST_BUSY;
    main_wen  = flush_i | (state == ST_FULL ? out_fire : in_fire & (state == ST_EMPTY | out_fire));
    main_din  = flush_i ? BUBBLE_VAL : state == ST_FULL ? skid_q : in_data_i;
    skid_wen  = flush_i | (state == ST_BUSY & in_fire & ~out_fire);
    skid_din  = flush_i ? BUBBLE_VAL : in_data_i;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nxt;
      rdy_q <= state_nxt != ST_FULL;
    end
  pipe_skid_stage_reg #(.W(DATA_W), .RST_VAL(BUBBLE_VAL)) u_main (
    .clk(clk), .rst(rst), .wen(main_wen), .din(main_din), .dout(main_q)
  );
  pipe_skid_stage_reg #(.W(DATA_W), .RST_VAL(BUBBLE_VAL)) u_skid (
    .clk(clk), .rst(rst), .wen(skid_wen), .din(skid_din), .dout(skid_q)
  );
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and scoreboarded checks of pipe_skid_stage (DATA_W=32, bubble 0x13, SKID=1)
module tb_pipe_skid_stage;
  localparam logic [31:0] BUB = 32'h0000_0013;
  logic clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0] occ;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic r;
  always #5 clk = ~clk;
  pipe_skid_stage #(.DATA_W(32), .BUBBLE_VAL(BUB), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .occ_o(occ)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic st(input string tag, input logic v, input logic [31:0] d, input logic [1:0] o, input logic rdy);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_occ"}, 32'(occ), 32'(o));
    chk({tag, "_rdy"}, 32'(in_ready), 32'(rdy));
  endtask
  initial begin
    rst = 1; in_valid = 0; in_data = 0; flush = 0; out_ready = 0;
    tick; tick;
    st("rst", 0, BUB, 0, 0);
    rst = 0; #1;
    st("post_rst", 0, BUB, 0, 1);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = 32'hA000_0000 + 32'(i);
      tick;
      st($sformatf("strm%0d", i), 1, 32'hA000_0000 + 32'(i), 1, 1);
    end
    in_valid = 0; tick;
    st("strm_end", 0, BUB, 0, 1);
    out_ready = 0; in_valid = 1; in_data = 32'hB1;
    tick; st("b1", 1, 32'hB1, 1, 1);
    in_data = 32'hB2;
    tick; st("b2_full", 1, 32'hB1, 2, 0);
    in_valid = 0;
    tick; st("b_stall", 1, 32'hB1, 2, 0);
    out_ready = 1;
    tick; st("b_rel1", 1, 32'hB2, 1, 1);
    tick; st("b_rel2", 0, BUB, 0, 1);
    out_ready = 0; in_valid = 1; in_data = 32'hD1;
    tick; in_data = 32'hD2;
    tick; st("d_full", 1, 32'hD1, 2, 0);
    flush = 1; in_data = 32'hC1;
    tick; flush = 0; in_valid = 0;
    st("flush_full", 0, BUB, 0, 1);
    out_ready = 1;
    tick; st("flush_idle", 0, BUB, 0, 1);
    out_ready = 0; in_valid = 1; in_data = 32'hD3;
    tick; st("d3_busy", 1, 32'hD3, 1, 1);
    flush = 1; in_data = 32'hC2;
    tick; flush = 0; in_valid = 0;
    st("flush_busy", 0, BUB, 0, 1);
    in_valid = 1; in_data = 32'hE1;
    tick; in_data = 32'hE2;
    tick; st("e_full", 1, 32'hE1, 2, 0);
    in_valid = 0; rst = 1;
    tick; st("rst_full", 0, BUB, 0, 0);
    rst = 0; out_ready = 1;
    tick; st("rst_after", 0, BUB, 0, 1);
    tick; st("rst_after2", 0, BUB, 0, 1);
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      chk("sb_occ", 32'(occ), 32'(q.size()));
      in_valid = 1'($urandom); in_data = $urandom; out_ready = 1'($urandom);
      #1; r = in_ready;
      out_ready = ~out_ready; #1;
      chk("rdy_comb", 32'(in_ready), 32'(r));
      out_ready = ~out_ready; #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_spurious", 32'(out_valid), 32'd0);
        else chk("sb_data", out_data, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(in_data);
    end
    @(negedge clk);
    chk("sb_final_occ", 32'(occ), 32'(q.size()));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
